// File: rtl/crossbar_port_arbiter_pkg.sv
// crossbar_port_arbiter_pkg
//   Definitions shared across the crossbar slice: the output-port arbiter
//   state encoding and the fixed width of the AXI-Stream tdest field.
package crossbar_port_arbiter_pkg;

   localparam int unsigned TDEST_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

endpackage

// File: rtl/crossbar_port_arbiter_rr_pick.sv
// rr_pick
//   Round-robin priority pick: returns a one-hot grant for the first set bit
//   of req found scanning upward from ptr, wrapping modulo P_N.
//   req   : request vector, one bit per requester
//   ptr   : index holding highest priority this round
//   grant : one-hot pick, all zero when req is all zero
module rr_pick #(
   parameter int unsigned P_N     = 4,
   parameter int unsigned P_PTR_W = 2
) (
   input  logic [P_N-1:0]     req,
   input  logic [P_PTR_W-1:0] ptr,
   output logic [P_N-1:0]     grant
);

   logic found;

   // Outer loop walks priority order; inner loop keeps every bit index a
   // loop constant so the pick is a plain priority mux after unrolling.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned off = 0; off < P_N; off++) begin
         for (int unsigned i = 0; i < P_N; i++) begin
            if (!found && req[i] && (i == ((32'(ptr) + off) % P_N))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/crossbar_port_arbiter.sv
// crossbar_port_arbiter
//   One output port of an AXI-Stream crossbar. Inputs whose tdest matches
//   P_PORT_ID compete round-robin; the winner owns the port for a whole
//   packet (released only by an accepted tlast), with one idle cycle between
//   packets. The data path from the owner to the output is combinational.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   s_axis_rx_*        : P_CROSSBAR_N packed input streams (slice i = input i)
//   m_axis_tx_*        : output stream
//   o_grant            : one-hot current owner, zero when idle
//   o_busy             : high while a packet is being transferred
//   o_pkt_cnt          : completed packets, wraps at 16 bits
module crossbar_port_arbiter
   import crossbar_port_arbiter_pkg::*;
#(
   parameter int unsigned P_CROSSBAR_N = 4,
   parameter int unsigned P_PORT_ID    = 0,
   parameter int unsigned P_DATA_WIDTH = 64
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic [P_CROSSBAR_N-1:0]               s_axis_rx_tvalid,
   input  logic [P_CROSSBAR_N*P_DATA_WIDTH-1:0]  s_axis_rx_tdata,
   input  logic [P_CROSSBAR_N-1:0]               s_axis_rx_tlast,
   input  logic [P_CROSSBAR_N*P_DATA_WIDTH/8-1:0] s_axis_rx_tkeep,
   input  logic [P_CROSSBAR_N-1:0]               s_axis_rx_tuser,
   input  logic [P_CROSSBAR_N*TDEST_W-1:0]       s_axis_rx_tdest,
   output logic [P_CROSSBAR_N-1:0]               s_axis_rx_tready,
   output logic                                  m_axis_tx_tvalid,
   output logic [P_DATA_WIDTH-1:0]               m_axis_tx_tdata,
   output logic                                  m_axis_tx_tlast,
   output logic [P_DATA_WIDTH/8-1:0]             m_axis_tx_tkeep,
   output logic                                  m_axis_tx_tuser,
   input  logic                                  m_axis_tx_tready,
   output logic [P_CROSSBAR_N-1:0]               o_grant,
   output logic                                  o_busy,
   output logic [15:0]                           o_pkt_cnt
);

   localparam int unsigned KEEP_W = P_DATA_WIDTH / 8;
   localparam int unsigned PTR_W  = (P_CROSSBAR_N > 1) ? $clog2(P_CROSSBAR_N) : 1;

   state_t                  state;
   logic [P_CROSSBAR_N-1:0] grant_q;
   logic [P_CROSSBAR_N-1:0] req;
   logic [P_CROSSBAR_N-1:0] pick;
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        g_idx;
   logic [PTR_W-1:0]        next_ptr;
   logic [15:0]             pkt_cnt;
   logic                    last_acc;

   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < P_CROSSBAR_N; i++) begin
         req[i] = s_axis_rx_tvalid[i] &&
                  (s_axis_rx_tdest[i*TDEST_W +: TDEST_W] == TDEST_W'(P_PORT_ID));
      end
   end

   rr_pick #(
      .P_N     (P_CROSSBAR_N),
      .P_PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick)
   );

   // Owner mux: grant_q is one-hot, so at most one slice is selected.
   always_comb begin
      m_axis_tx_tvalid = 1'b0;
      m_axis_tx_tdata  = '0;
      m_axis_tx_tlast  = 1'b0;
      m_axis_tx_tkeep  = '0;
      m_axis_tx_tuser  = 1'b0;
      s_axis_rx_tready = '0;
      if (state == ST_XFER) begin
         for (int unsigned i = 0; i < P_CROSSBAR_N; i++) begin
            if (grant_q[i]) begin
               m_axis_tx_tvalid    = s_axis_rx_tvalid[i];
               m_axis_tx_tdata     = s_axis_rx_tdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
               m_axis_tx_tlast     = s_axis_rx_tlast[i];
               m_axis_tx_tkeep     = s_axis_rx_tkeep[i*KEEP_W +: KEEP_W];
               m_axis_tx_tuser     = s_axis_rx_tuser[i];
               s_axis_rx_tready[i] = m_axis_tx_tready;
            end
         end
      end
   end

   always_comb begin
      g_idx = '0;
      for (int unsigned i = 0; i < P_CROSSBAR_N; i++) begin
         if (grant_q[i]) g_idx = PTR_W'(i);
      end
   end

   assign next_ptr = (g_idx == PTR_W'(P_CROSSBAR_N - 1)) ? '0 : g_idx + 1'b1;
   assign last_acc = m_axis_tx_tvalid && m_axis_tx_tready && m_axis_tx_tlast;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= ST_IDLE;
         grant_q <= '0;
         rr_ptr  <= '0;
         pkt_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  grant_q <= pick;
                  state   <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (last_acc) begin
                  grant_q <= '0;
                  rr_ptr  <= next_ptr;
                  pkt_cnt <= pkt_cnt + 16'd1;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant   = grant_q;
   assign o_busy    = (state == ST_XFER);
   assign o_pkt_cnt = pkt_cnt;

endmodule

// File: tb/tb_crossbar_port_arbiter.sv
module tb_crossbar_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int KW = DW / 8;

   typedef struct {
      int          src;
      logic [63:0] data;
      logic        last;
      logic [7:0]  keep;
      logic        user;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_tvalid;
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]    s_tlast;
   logic [N*KW-1:0] s_tkeep;
   logic [N-1:0]    s_tuser;
   logic [N*3-1:0]  s_tdest;
   logic [N-1:0]    s_tready;
   logic            m_tvalid;
   logic [DW-1:0]   m_tdata;
   logic            m_tlast;
   logic [KW-1:0]   m_tkeep;
   logic            m_tuser;
   logic            tx_tready;
   logic [N-1:0]    o_grant;
   logic            o_busy;
   logic [15:0]     o_pkt_cnt;

   always #5 clk = ~clk;

   crossbar_port_arbiter #(
      .P_CROSSBAR_N (N),
      .P_PORT_ID    (0),
      .P_DATA_WIDTH (DW)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .s_axis_rx_tvalid (s_tvalid),
      .s_axis_rx_tdata  (s_tdata),
      .s_axis_rx_tlast  (s_tlast),
      .s_axis_rx_tkeep  (s_tkeep),
      .s_axis_rx_tuser  (s_tuser),
      .s_axis_rx_tdest  (s_tdest),
      .s_axis_rx_tready (s_tready),
      .m_axis_tx_tvalid (m_tvalid),
      .m_axis_tx_tdata  (m_tdata),
      .m_axis_tx_tlast  (m_tlast),
      .m_axis_tx_tkeep  (m_tkeep),
      .m_axis_tx_tuser  (m_tuser),
      .m_axis_tx_tready (tx_tready),
      .o_grant          (o_grant),
      .o_busy           (o_busy),
      .o_pkt_cnt        (o_pkt_cnt)
   );

   int errors = 0;
   int checks = 0;

   // source models
   int         src_left [N];
   int         src_len  [N];
   int         src_beat [N];
   int         src_pkt  [N];
   int         src_hold [N];
   int         drop_at  [N];
   int         drop_len [N];
   logic [2:0] src_dest [N];

   // reference arbiter model and scoreboard (expected grant order)
   logic  model_busy = 1'b0;
   int    owner      = 0;
   int    beats_out  = 0;
   int    stall_beat = -1;
   int    stall_left = 0;
   int    stall_seen = 0;
   beat_t sb[$];

   function automatic logic [63:0] beat_data(int s, int p, int b);
      return {8'hA5, s[7:0], p[15:0], b[31:0]};
   endfunction

   function automatic logic [7:0] keep_of(int b, int len);
      return (b == len - 1) ? 8'h0F : 8'hFF;
   endfunction

   function automatic logic [N-1:0] onehot(int s);
      logic [N-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   task automatic push_pkt(input int s, input int p, input int len);
      beat_t e;
      for (int b = 0; b < len; b++) begin
         e.src  = s;
         e.data = beat_data(s, p, b);
         e.last = (b == len - 1);
         e.keep = keep_of(b, len);
         e.user = (b == 0);
         sb.push_back(e);
      end
   endtask

   task automatic apply_src();
      for (int i = 0; i < N; i++) begin
         s_tvalid[i]          = (src_left[i] > 0) && (src_hold[i] == 0);
         s_tdata[i*DW +: DW]  = beat_data(i, src_pkt[i], src_beat[i]);
         s_tlast[i]           = (src_beat[i] == src_len[i] - 1);
         s_tkeep[i*KW +: KW]  = keep_of(src_beat[i], src_len[i]);
         s_tuser[i]           = (src_beat[i] == 0);
         s_tdest[i*3 +: 3]    = src_dest[i];
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < N; i++) begin
         src_left[i] = 0;
         src_len[i]  = 1;
         src_beat[i] = 0;
         src_pkt[i]  = 0;
         src_hold[i] = 0;
         drop_at[i]  = -1;
         drop_len[i] = 0;
         src_dest[i] = 3'd0;
      end
      apply_src();
   endtask

   task automatic setup_src(input int i, input int len, input int npk, input logic [2:0] dest);
      src_left[i] = npk;
      src_len[i]  = len;
      src_dest[i] = dest;
   endtask

   // One clock: check/monitor at negedge, advance sources 1 time unit after posedge.
   task automatic step();
      logic [N-1:0] exp_grant, exp_tready, req, acc;
      logic         exp_mvalid;
      beat_t        e;
      @(negedge clk);
      acc = '0;
      if (rst_n) begin
         exp_grant  = model_busy ? onehot(owner) : '0;
         exp_mvalid = model_busy && s_tvalid[owner];
         exp_tready = model_busy ? (onehot(owner) & {N{tx_tready}}) : '0;
         checks++;
         if (o_busy !== model_busy) begin
            errors++; $display("FAIL busy: got %b expected %b at %0t", o_busy, model_busy, $time);
         end
         checks++;
         if (o_grant !== exp_grant) begin
            errors++; $display("FAIL grant: got %b expected %b at %0t", o_grant, exp_grant, $time);
         end
         checks++;
         if (m_tvalid !== exp_mvalid) begin
            errors++; $display("FAIL m_tvalid: got %b expected %b at %0t", m_tvalid, exp_mvalid, $time);
         end
         checks++;
         if (s_tready !== exp_tready) begin
            errors++; $display("FAIL s_tready: got %b expected %b at %0t", s_tready, exp_tready, $time);
         end
         if (exp_mvalid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL sb_empty: got beat with no expected beat at %0t", $time);
            end else begin
               e = sb[0];
               if ({m_tdata, m_tlast, m_tkeep, m_tuser} !== {e.data, e.last, e.keep, e.user}) begin
                  errors++;
                  $display("FAIL beat: got data=%h last=%b keep=%h user=%b expected data=%h last=%b keep=%h user=%b",
                           m_tdata, m_tlast, m_tkeep, m_tuser, e.data, e.last, e.keep, e.user);
               end
               if (tx_tready) begin
                  void'(sb.pop_front());
                  acc = onehot(owner);
                  beats_out++;
                  if (e.last) begin
                     model_busy = 1'b0;
                     beats_out  = 0;
                  end
               end else begin
                  stall_seen++;
               end
            end
         end else if (!model_busy) begin
            for (int i = 0; i < N; i++) req[i] = s_tvalid[i] && (s_tdest[i*3 +: 3] == 3'd0);
            if (|req) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_request: got req=%b expected no request", req);
               end else begin
                  model_busy = 1'b1;
                  owner      = sb[0].src;
               end
            end
         end
      end else begin
         model_busy = 1'b0;
         owner      = 0;
         beats_out  = 0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (src_hold[i] > 0) src_hold[i]--;
         if (acc[i]) begin
            src_beat[i]++;
            if (src_beat[i] == src_len[i]) begin
               src_beat[i] = 0;
               src_pkt[i]++;
               src_left[i]--;
            end else if (src_pkt[i] == 0 && src_beat[i] == drop_at[i]) begin
               src_hold[i] = drop_len[i];
            end
         end
      end
      tx_tready = 1'b1;
      if (stall_left > 0 && model_busy && beats_out == stall_beat) begin
         tx_tready = 1'b0;
         stall_left--;
      end
      apply_src();
   endtask

   task automatic run_pkts(input int budget, output int n);
      n = 0;
      while ((sb.size() > 0 || model_busy) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL timeout: got %0d cycles with %0d beats pending expected completion", n, sb.size());
      end
   endtask

   task automatic check_cycles(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++; $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_cnt(input string name, input logic [15:0] exp);
      checks++;
      if (o_pkt_cnt !== exp) begin
         errors++; $display("FAIL %s: got %0d expected %0d", name, o_pkt_cnt, exp);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({o_grant, m_tvalid, s_tready, o_busy} !== {{N{1'b0}}, 1'b0, {N{1'b0}}, 1'b0}) begin
         errors++;
         $display("FAIL %s: got grant=%b tvalid=%b tready=%b busy=%b expected all zero",
                  name, o_grant, m_tvalid, s_tready, o_busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      check_idle_outputs("reset_outputs");
      check_cnt("reset_pkt_cnt", 16'd0);
      rst_n = 1'b1;
   endtask

   task automatic test_four_way();
      int n;
      clear_sources();
      for (int i = 0; i < N; i++) begin
         setup_src(i, 16, 1, 3'd0);
         push_pkt(i, 0, 16);
      end
      apply_src();
      run_pkts(300, n);
      check_cycles("four_way_cycles", n, 68);
      check_cnt("four_way_pkt_cnt", 16'd4);
   endtask

   task automatic test_stall();
      int n;
      clear_sources();
      setup_src(0, 16, 1, 3'd0);
      push_pkt(0, 0, 16);
      stall_beat = 15;
      stall_left = 1;
      stall_seen = 0;
      apply_src();
      run_pkts(100, n);
      check_cycles("stall_cycles", n, 18);
      check_cycles("stall_seen", stall_seen, 1);
      check_cnt("stall_pkt_cnt", 16'd5);
      stall_beat = -1;
   endtask

   task automatic test_tdest_filter();
      int n;
      clear_sources();
      setup_src(1, 4, 1, 3'd2);
      setup_src(3, 4, 1, 3'd0);
      push_pkt(3, 0, 4);
      apply_src();
      run_pkts(50, n);
      check_cycles("tdest_cycles", n, 5);
      repeat (4) step();
      check_cycles("tdest_src1_beats", src_beat[1], 0);
      check_cnt("tdest_pkt_cnt", 16'd6);
   endtask

   task automatic test_alternate();
      int n;
      clear_sources();
      setup_src(0, 4, 2, 3'd0);
      setup_src(2, 4, 2, 3'd0);
      push_pkt(0, 0, 4);
      push_pkt(2, 0, 4);
      push_pkt(0, 1, 4);
      push_pkt(2, 1, 4);
      apply_src();
      run_pkts(100, n);
      check_cycles("alternate_cycles", n, 20);
      check_cnt("alternate_pkt_cnt", 16'd10);
   endtask

   task automatic test_mid_reset();
      int n;
      clear_sources();
      setup_src(1, 16, 1, 3'd0);
      setup_src(3, 16, 1, 3'd0);
      push_pkt(3, 0, 16);
      apply_src();
      n = 0;
      while (beats_out < 8 && n < 100) begin
         step();
         n++;
      end
      check_cycles("mid_reset_beats_before", beats_out, 8);
      rst_n = 1'b0;
      sb.delete();
      step();
      rst_n = 1'b1;
      check_idle_outputs("mid_reset_outputs");
      check_cnt("mid_reset_pkt_cnt", 16'd0);
      clear_sources();
      setup_src(1, 2, 1, 3'd0);
      setup_src(3, 2, 1, 3'd0);
      push_pkt(1, 0, 2);
      push_pkt(3, 0, 2);
      apply_src();
      run_pkts(50, n);
      check_cycles("after_reset_cycles", n, 6);
      check_cnt("after_reset_pkt_cnt", 16'd2);
   endtask

   task automatic test_drop_valid();
      int n;
      clear_sources();
      setup_src(0, 8, 1, 3'd0);
      setup_src(1, 8, 1, 3'd0);
      drop_at[0]  = 3;
      drop_len[0] = 3;
      push_pkt(0, 0, 8);
      push_pkt(1, 0, 8);
      apply_src();
      run_pkts(100, n);
      check_cycles("drop_cycles", n, 21);
      check_cnt("drop_pkt_cnt", 16'd4);
   endtask

   initial begin
      rst_n     = 1'b0;
      tx_tready = 1'b1;
      clear_sources();
      test_reset();
      test_four_way();
      test_stall();
      test_tdest_filter();
      test_alternate();
      test_mid_reset();
      test_drop_valid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
